// File: rtl/oversample_vote.sv
// ----------------------------------------------------------------------------
// oversample_vote
//   Reduces RATIO oversampled bits per channel to one decided bit. Each window
//   takes RATIO qualified samples. The decision is either a majority vote
//   (count of ones >= thresh) or the sample taken at the centre of the window.
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst         asynchronous reset, active low
//   en          sample qualifier; only en=1 cycles consume a sample
//   data_in     raw samples; bit c belongs to channel c
//   thresh      majority threshold, sampled at the final-sample edge
//   mode        0 = majority vote, 1 = centre-sample pick (sampled at final edge)
//   resync      synchronous window restart; has priority over en
//   data_out    registered decided bits; held between strobes
//   data_valid  one-cycle strobe marking a new data_out
// ----------------------------------------------------------------------------
module oversample_vote #(
  parameter int CHANNELS = 1,
  parameter int RATIO    = 20,
  parameter int ACC_W    = $clog2(RATIO + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] data_in,
  input  logic [ACC_W-1:0]    thresh,
  input  logic                mode,
  input  logic                resync,
  output logic [CHANNELS-1:0] data_out,
  output logic                data_valid
);

  localparam int               CNT_W  = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] CNT_CENTRE = CNT_W'(RATIO / 2);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [ACC_W-1:0] ACC_ZERO   = ACC_W'(0);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q [CHANNELS];
  logic [ACC_W-1:0]    acc_d [CHANNELS];
  logic [CHANNELS-1:0] centre_q, centre_d;
  logic [CHANNELS-1:0] data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;

  logic                last_s;
  logic                at_centre_s;
  logic [ACC_W-1:0]    sum_s [CHANNELS];
  logic [CHANNELS-1:0] vote_s;
  logic [CHANNELS-1:0] centre_pick_s;

  assign last_s      = (cnt_q == CNT_LAST);
  assign at_centre_s = (cnt_q == CNT_CENTRE);

  // Per-channel window sums including the current sample, and both decisions.
  // The sum never exceeds RATIO, so ACC_W bits cannot overflow. When the centre
  // slot is also the final slot (RATIO=2) the live sample is the centre sample.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sum_s[c]         = acc_q[c] + {{(ACC_W-1){1'b0}}, data_in[c]};
      vote_s[c]        = (sum_s[c] >= thresh);
      centre_pick_s[c] = at_centre_s ? data_in[c] : centre_q[c];
    end
  end

  // Next-state: resync beats en; the final sample closes the window.
  always_comb begin
    cnt_d        = cnt_q;
    centre_d     = centre_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      acc_d[c] = acc_q[c];
    end

    if (resync) begin
      cnt_d    = CNT_ZERO;
      centre_d = {CHANNELS{1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
        acc_d[c] = ACC_ZERO;
      end
    end else if (en) begin
      if (last_s) begin
        cnt_d        = CNT_ZERO;
        centre_d     = {CHANNELS{1'b0}};
        data_valid_d = 1'b1;
        data_out_d   = mode ? centre_pick_s : vote_s;
        for (int c = 0; c < CHANNELS; c++) begin
          acc_d[c] = ACC_ZERO;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
        for (int c = 0; c < CHANNELS; c++) begin
          acc_d[c] = sum_s[c];
        end
        if (at_centre_s) begin
          centre_d = data_in;
        end else begin
          centre_d = centre_q;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= CNT_ZERO;
      centre_q     <= {CHANNELS{1'b0}};
      data_out_q   <= {CHANNELS{1'b0}};
      data_valid_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= ACC_ZERO;
      end
    end else begin
      cnt_q        <= cnt_d;
      centre_q     <= centre_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_oversample_vote.sv
// ----------------------------------------------------------------------------
// tb_oversample_vote
//   Directed bench for oversample_vote with CHANNELS=2, RATIO=20. Inputs are
//   driven 1ns after the rising edge and outputs sampled at the same point,
//   so every observation reflects the edge just taken.
// ----------------------------------------------------------------------------
module tb_oversample_vote;

  localparam int CH    = 2;
  localparam int RATIO = 20;
  localparam int ACC_W = $clog2(RATIO + 1);

  logic             clk;
  logic             rst;
  logic             en;
  logic [CH-1:0]    data_in;
  logic [ACC_W-1:0] thresh;
  logic             mode;
  logic             resync;
  logic [CH-1:0]    data_out;
  logic             data_valid;

  int checks;
  int failures;
  int strobes;

  oversample_vote #(.CHANNELS(CH), .RATIO(RATIO)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data_in    (data_in),
    .thresh     (thresh),
    .mode       (mode),
    .resync     (resync),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; counts strobes seen after the edge.
  task automatic step(input logic e, input logic [CH-1:0] d);
    en      = e;
    data_in = d;
    @(posedge clk);
    #1;
    if (data_valid) strobes++;
  endtask

  task automatic run(input int n, input logic [CH-1:0] d);
    for (int i = 0; i < n; i++) step(1'b1, d);
  endtask

  int s0;
  int n_en;
  logic e_v;

  initial begin
    checks   = 0;
    failures = 0;
    strobes  = 0;
    rst      = 1'b0;
    en       = 1'b0;
    data_in  = 2'b00;
    thresh   = 5'd10;
    mode     = 1'b0;
    resync   = 1'b0;
    #2;
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_valid", 32'(data_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic window: ch0 all ones, ch1 all zeros.
    s0 = strobes;
    run(19, 2'b01);
    check("basic_no_early_strobe", 32'(strobes - s0), 32'd0);
    step(1'b1, 2'b01);
    check("basic_valid", 32'(data_valid), 32'h1);
    check("basic_data_out", 32'(data_out), 32'h1);
    step(1'b0, 2'b00);
    check("basic_valid_one_cycle", 32'(data_valid), 32'h0);
    check("basic_hold", 32'(data_out), 32'h1);

    // Exactly 10 ones in the last ten slots (includes final sample) -> 1.
    run(10, 2'b00);
    run(10, 2'b01);
    check("ten_ones", 32'(data_out), 32'h1);
    // Exactly 9 ones -> 0.
    run(11, 2'b00);
    run(9, 2'b01);
    check("nine_ones", 32'(data_out), 32'h0);

    // Threshold extremes.
    thresh = 5'd0;
    run(20, 2'b00);
    check("thresh_zero", 32'(data_out), 32'h3);
    thresh = 5'd21;
    run(20, 2'b11);
    check("thresh_above_ratio", 32'(data_out), 32'h0);
    thresh = 5'd10;

    // 20 enabled samples spread over 35 cycles; 20th enable falls on i=33.
    s0   = strobes;
    n_en = 0;
    for (int i = 0; i < 35; i++) begin
      e_v = ((i % 7) != 2) && ((i % 7) != 4) && ((i % 7) != 6);
      step(e_v, 2'b10);
      if (e_v) n_en++;
      if (i == 32) check("gaps_no_early_strobe", 32'(strobes - s0), 32'd0);
      if (i == 33) check("gaps_strobe_at_20th", 32'(data_valid), 32'h1);
    end
    check("gaps_enable_count", 32'(n_en), 32'd20);
    check("gaps_single_strobe", 32'(strobes - s0), 32'd1);
    check("gaps_data_out", 32'(data_out), 32'h2);

    // Resync at cnt=7, then a fresh window of all ones.
    s0 = strobes;
    run(7, 2'b11);
    resync = 1'b1;
    step(1'b1, 2'b11);
    resync = 1'b0;
    check("resync_no_strobe", 32'(data_valid), 32'h0);
    check("resync_keeps_data_out", 32'(data_out), 32'h2);
    run(19, 2'b11);
    check("resync_no_early_strobe", 32'(strobes - s0), 32'd0);
    step(1'b1, 2'b11);
    check("resync_strobe", 32'(data_valid), 32'h1);
    check("resync_data_out", 32'(data_out), 32'h3);

    // Resync on the final slot suppresses the strobe.
    s0 = strobes;
    run(19, 2'b00);
    resync = 1'b1;
    step(1'b1, 2'b00);
    resync = 1'b0;
    check("resync_final_suppress", 32'(strobes - s0), 32'd0);
    check("resync_final_hold", 32'(data_out), 32'h3);
    run(20, 2'b00);
    check("resync_final_next", 32'(strobes - s0), 32'd1);
    check("resync_final_data", 32'(data_out), 32'h0);

    // Centre pick: ch0 one only at cnt=10.
    mode = 1'b1;
    run(10, 2'b00);
    step(1'b1, 2'b01);
    run(9, 2'b00);
    check("centre_mode1", 32'(data_out), 32'h1);
    mode = 1'b0;
    run(10, 2'b00);
    step(1'b1, 2'b01);
    run(9, 2'b00);
    check("centre_mode0", 32'(data_out), 32'h0);
    // Mode is sampled only at the final edge.
    run(10, 2'b00);
    step(1'b1, 2'b01);
    run(8, 2'b00);
    mode = 1'b1;
    step(1'b1, 2'b00);
    check("mode_sampled_at_final", 32'(data_out), 32'h1);
    mode = 1'b0;

    // Reset mid-window at cnt=12 with data_out=11.
    run(20, 2'b11);
    check("pre_reset_data_out", 32'(data_out), 32'h3);
    run(12, 2'b11);
    rst = 1'b0;
    #2;
    check("async_reset_data_out", 32'(data_out), 32'h0);
    check("async_reset_valid", 32'(data_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    s0 = strobes;
    run(19, 2'b01);
    check("post_reset_no_early_strobe", 32'(strobes - s0), 32'd0);
    step(1'b1, 2'b01);
    check("post_reset_strobe", 32'(data_valid), 32'h1);
    check("post_reset_data_out", 32'(data_out), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
